// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter
//   Shares the single data-SRAM port between the neurocore EX-stage load/store
//   path and a host loader. The core has fixed priority; a host wait counter
//   forces a one-cycle core stall so the host always makes progress.
//
// Ports
//   clk, rst_n                              clock, async active-low reset
//   core_en/core_we/core_addr/core_din      core request (combinational from EX)
//   core_dout                               core read data, cycle after issue
//   core_stall                              registered, core must hold while high
//   core_drop                               sticky: core_en seen during a stall
//   host_req/host_we/host_addr/host_wdata   host request, held until host_gnt
//   host_gnt                                combinational, host issued this cycle
//   host_rvalid/host_rdata                  host read return, rdata 0 when invalid
//   ram_en/ram_we/ram_addr/ram_din          SRAM request, all 0 when idle
//   ram_dout                                SRAM read data, 1 cycle latency
//
// state | meaning
// ------+-----------------------------------------------------------------
// ARB   | core wins when core_en; host served otherwise; count host losses
// STALL | one cycle: core_stall high, host served unconditionally
module data_ram_arbiter #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 8,
   parameter int WAIT_W   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  core_en,
   input  logic [DATA_W/8-1:0]   core_we,
   input  logic [ADDR_W-1:0]     core_addr,
   input  logic [DATA_W-1:0]     core_din,
   output logic [DATA_W-1:0]     core_dout,
   output logic                  core_stall,
   output logic                  core_drop,
   input  logic                  host_req,
   input  logic [DATA_W/8-1:0]   host_we,
   input  logic [ADDR_W-1:0]     host_addr,
   input  logic [DATA_W-1:0]     host_wdata,
   output logic                  host_gnt,
   output logic                  host_rvalid,
   output logic [DATA_W-1:0]     host_rdata,
   output logic                  ram_en,
   output logic [DATA_W/8-1:0]   ram_we,
   output logic [ADDR_W-1:0]     ram_addr,
   output logic [DATA_W-1:0]     ram_din,
   input  logic [DATA_W-1:0]     ram_dout
);

   localparam int NB = DATA_W / 8;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_SAT   = {WAIT_W{1'b1}};

   typedef enum logic {ARB, STALL} state_t;
   typedef enum logic [1:0] {RD_NONE, RD_CORE, RD_HOST} owner_t;

   state_t            state;
   owner_t            rd_owner;
   logic [WAIT_W-1:0] wait_cnt;
   logic [WAIT_W-1:0] wait_inc;
   logic              core_issue;
   logic              host_issue;
   logic              host_lost;

   // Issue decisions are gated by rst_n so the RAM port and host_gnt drop to
   // zero the moment reset asserts, not at the next clock.
   always_comb begin
      core_issue = 1'b0;
      host_issue = 1'b0;
      host_lost  = 1'b0;
      if (rst_n) begin
         if (state == STALL) begin
            host_issue = host_req;
         end else begin
            core_issue = core_en;
            host_issue = host_req & ~core_en;
            host_lost  = host_req & core_en;
         end
      end
   end

   assign wait_inc = (wait_cnt == WAIT_SAT) ? wait_cnt : wait_cnt + 1'b1;

   always_comb begin
      ram_en   = core_issue | host_issue;
      ram_we   = '0;
      ram_addr = '0;
      ram_din  = '0;
      if (core_issue) begin
         ram_we   = core_we;
         ram_addr = core_addr;
         ram_din  = core_din;
      end else if (host_issue) begin
         ram_we   = host_we;
         ram_addr = host_addr;
         ram_din  = host_wdata;
      end
   end

   assign host_gnt    = host_issue;
   assign host_rvalid = (rd_owner == RD_HOST);
   assign host_rdata  = host_rvalid ? ram_dout : '0;
   assign core_dout   = (rd_owner == RD_CORE) ? ram_dout : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         wait_cnt   <= '0;
         core_stall <= 1'b0;
         core_drop  <= 1'b0;
      end else begin
         case (state)
            ARB: begin
               if (host_lost) begin
                  wait_cnt <= wait_inc;
                  if (wait_inc == WAIT_LIMIT) begin
                     state      <= STALL;
                     core_stall <= 1'b1;
                  end
               end else begin
                  wait_cnt <= '0;
               end
            end
            STALL: begin
               // Core was told to hold; any request now is lost for good.
               if (core_en) core_drop <= 1'b1;
               state      <= ARB;
               core_stall <= 1'b0;
               wait_cnt   <= '0;
            end
            default: begin
               state      <= ARB;
               core_stall <= 1'b0;
               wait_cnt   <= '0;
            end
         endcase
      end
   end

   // Remembers who owns the data coming back on ram_dout next cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_owner <= RD_NONE;
      else if (core_issue && core_we == '0)
         rd_owner <= RD_CORE;
      else if (host_issue && host_we == '0)
         rd_owner <= RD_HOST;
      else
         rd_owner <= RD_NONE;
   end

   logic unused_nb;
   assign unused_nb = (NB == 0);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter with a small byte-lane SRAM model.
// Read results are predicted at issue time and compared on return.
module tb_data_ram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_en;
   logic [3:0]  core_we;
   logic [15:0] core_addr;
   logic [31:0] core_din;
   logic [31:0] core_dout;
   logic        core_stall;
   logic        core_drop;
   logic        host_req;
   logic [3:0]  host_we;
   logic [15:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_gnt;
   logic        host_rvalid;
   logic [31:0] host_rdata;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [15:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout = 32'h0;

   int errors = 0;
   int checks = 0;

   logic [31:0] core_q[$];
   logic [31:0] host_q[$];

   data_ram_arbiter #(
      .ADDR_W(16), .DATA_W(32), .MAX_WAIT(8), .WAIT_W(4)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .core_en(core_en), .core_we(core_we), .core_addr(core_addr), .core_din(core_din),
      .core_dout(core_dout), .core_stall(core_stall), .core_drop(core_drop),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // SRAM model: word index addr[9:2]; word i starts as C0DE_0000|i, except
   // word 4 (addr 0x0010) = 0x12345678. Non-read cycles return garbage.
   logic [31:0] mem [0:255];
   bit init_done = 1'b0;
   always @(posedge clk) begin
      if (!init_done) begin
         for (int i = 0; i < 256; i++)
            mem[i] <= (i == 4) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(i));
         init_done <= 1'b1;
         ram_dout  <= 32'hDEAD_BEEF;
      end else if (ram_en && ram_we == 4'b0000) begin
         ram_dout <= mem[ram_addr[9:2]];
      end else begin
         ram_dout <= 32'hDEAD_BEEF;
         if (ram_en)
            for (int b = 0; b < 4; b++)
               if (ram_we[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_din[b*8 +: 8];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic check_reads();
      logic [31:0] e;
      if (host_q.size() != 0) begin
         e = host_q.pop_front();
         chk("host_rvalid", 32'(host_rvalid), 32'd1);
         chk("host_rdata", host_rdata, e);
      end else begin
         chk("host_rvalid_idle", 32'(host_rvalid), 32'd0);
         chk("host_rdata_idle", host_rdata, 32'd0);
      end
      if (core_q.size() != 0) begin
         e = core_q.pop_front();
         chk("core_dout", core_dout, e);
      end else begin
         chk("core_dout_idle", core_dout, 32'd0);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      check_reads();
   endtask

   task automatic idle();
      core_en   = 1'b0;
      core_we   = 4'h0;
      host_req  = 1'b0;
      host_we   = 4'h0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_core_dout"}, core_dout, 32'd0);
      chk({tag, "_core_stall"}, 32'(core_stall), 32'd0);
      chk({tag, "_core_drop"}, 32'(core_drop), 32'd0);
      chk({tag, "_host_gnt"}, 32'(host_gnt), 32'd0);
      chk({tag, "_host_rvalid"}, 32'(host_rvalid), 32'd0);
      chk({tag, "_host_rdata"}, host_rdata, 32'd0);
      chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
      chk({tag, "_ram_we"}, 32'(ram_we), 32'd0);
      chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
      chk({tag, "_ram_din"}, ram_din, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with requests present: every output must be zero.
      rst_n = 1'b0;
      core_en = 1'b1; core_we = 4'h0; core_addr = 16'h0010; core_din = 32'h0;
      host_req = 1'b1; host_we = 4'h0; host_addr = 16'h0200; host_wdata = 32'h0;
      #3;
      chk_all_zero("rst_init");
      repeat (2) @(posedge clk);
      #1;
      idle();
      rst_n = 1'b1;
      tick();

      // Core read of 0x0010.
      core_en = 1'b1; core_we = 4'h0; core_addr = 16'h0010;
      #1;
      chk("t2_ram_en", 32'(ram_en), 32'd1);
      chk("t2_ram_addr", 32'(ram_addr), 32'h0010);
      chk("t2_ram_we", 32'(ram_we), 32'd0);
      chk("t2_host_gnt", 32'(host_gnt), 32'd0);
      core_q.push_back(32'h1234_5678);
      tick();

      // Host byte-lane write with core idle.
      idle();
      host_req = 1'b1; host_we = 4'b1000; host_addr = 16'h0100; host_wdata = 32'hAB00_0000;
      #1;
      chk("t3_host_gnt", 32'(host_gnt), 32'd1);
      chk("t3_ram_we", 32'(ram_we), 32'h8);
      chk("t3_ram_din", ram_din, 32'hAB00_0000);
      chk("t3_ram_addr", 32'(ram_addr), 32'h0100);
      tick();

      // Core full-word write, then core read-back of the host-written word.
      idle();
      core_en = 1'b1; core_we = 4'hF; core_addr = 16'h0020; core_din = 32'h55AA_55AA;
      #1;
      chk("cw_ram_we", 32'(ram_we), 32'hF);
      chk("cw_ram_din", ram_din, 32'h55AA_55AA);
      tick();
      core_we = 4'h0; core_addr = 16'h0100;
      core_q.push_back(32'hABDE_0040);
      tick();

      // Host read, then core read the following cycle.
      idle();
      host_req = 1'b1; host_we = 4'h0; host_addr = 16'h0200;
      #1;
      chk("t5_host_gnt", 32'(host_gnt), 32'd1);
      chk("t5_ram_addr_h", 32'(ram_addr), 32'h0200);
      host_q.push_back(32'hC0DE_0080);
      tick();
      idle();
      core_en = 1'b1; core_we = 4'h0; core_addr = 16'h0204;
      #1;
      chk("t5_ram_addr_c", 32'(ram_addr), 32'h0204);
      core_q.push_back(32'hC0DE_0081);
      tick();

      // Host starved by continuous core reads: stall on the 9th cycle.
      idle();
      core_en = 1'b1; core_we = 4'h0; core_addr = 16'h0000;
      host_req = 1'b1; host_we = 4'hF; host_addr = 16'h0300; host_wdata = 32'h1122_3344;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("t4_gnt_lost", 32'(host_gnt), 32'd0);
         chk("t4_stall_lost", 32'(core_stall), 32'd0);
         core_q.push_back(32'hC0DE_0000);
         tick();
      end
      #1;
      chk("t4_stall", 32'(core_stall), 32'd1);
      chk("t4_gnt", 32'(host_gnt), 32'd1);
      chk("t4_ram_addr", 32'(ram_addr), 32'h0300);
      chk("t4_ram_we", 32'(ram_we), 32'hF);
      chk("t4_ram_din", ram_din, 32'h1122_3344);
      chk("t4_drop_pre", 32'(core_drop), 32'd0);
      tick();
      host_req = 1'b0;
      #1;
      chk("t4_stall_off", 32'(core_stall), 32'd0);
      chk("t4_drop", 32'(core_drop), 32'd1);
      chk("t4_core_back", 32'(ram_addr), 32'h0000);
      core_q.push_back(32'hC0DE_0000);
      tick();
      idle();
      #1;
      chk("t4_drop_sticky", 32'(core_drop), 32'd1);
      tick();

      // Host withdraws after 5 lost cycles: counter restarts.
      core_en = 1'b1; core_we = 4'h0; core_addr = 16'h0000;
      host_req = 1'b1; host_we = 4'hF; host_addr = 16'h0300; host_wdata = 32'h1122_3344;
      for (int i = 1; i <= 5; i++) begin
         #1;
         chk("t6_gnt_a", 32'(host_gnt), 32'd0);
         core_q.push_back(32'hC0DE_0000);
         tick();
      end
      host_req = 1'b0;
      #1;
      chk("t6_stall_drop", 32'(core_stall), 32'd0);
      core_q.push_back(32'hC0DE_0000);
      tick();
      host_req = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("t6_gnt_b", 32'(host_gnt), 32'd0);
         chk("t6_stall_b", 32'(core_stall), 32'd0);
         core_q.push_back(32'hC0DE_0000);
         tick();
      end
      core_en = 1'b0;
      #1;
      chk("t6_stall", 32'(core_stall), 32'd1);
      chk("t6_gnt", 32'(host_gnt), 32'd1);
      tick();
      idle();
      #1;
      chk("t6_stall_off", 32'(core_stall), 32'd0);
      tick();

      // Reset asserted in the middle of a host read.
      host_req = 1'b1; host_we = 4'h0; host_addr = 16'h0300;
      #1;
      chk("t1_gnt_pre", 32'(host_gnt), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk_all_zero("t1_rst");
      tick();
      rst_n = 1'b1;
      idle();
      tick();
      chk("t1_drop_clear", 32'(core_drop), 32'd0);

      // Host reissues the read after reset.
      host_req = 1'b1; host_we = 4'h0; host_addr = 16'h0300;
      #1;
      chk("t1_regnt", 32'(host_gnt), 32'd1);
      host_q.push_back(32'h1122_3344);
      tick();
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
